// File: rtl/exp_table_pkg.sv
// Shared types and helpers for the decaying-weight table generator.
// Holds the FSM state encoding, mode codes and the fixed-point unity helper.
package exp_table_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        EMIT = 2'd2,
        STEP = 2'd3
    } state_t;

    localparam logic MODE_EXP   = 1'b0;
    localparam logic MODE_GAUSS = 1'b1;

    function automatic logic [63:0] one_of(input int frac_w);
        return 64'd1 << frac_w;
    endfunction

endpackage

// File: rtl/exp_table_gen_if.sv
// Start/decay request and table-RAM write port of the table generator.
// The running-sum signal exists only when EXP_TABLE_SUM_EN is defined.
interface exp_table_gen_if #(
    parameter int DATA_W = 18,
    parameter int ADDR_W = 10
);
    logic              start;
    logic              mode;
    logic [DATA_W-1:0] decay;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic              busy;
    logic              done;
`ifdef EXP_TABLE_SUM_EN
    logic [DATA_W+ADDR_W-1:0] sum;

    modport master (input start, mode, decay, output data, addr, we, busy, done, sum);
    modport slave  (output start, mode, decay, input data, addr, we, busy, done, sum);
`else
    modport master (input start, mode, decay, output data, addr, we, busy, done);
    modport slave  (output start, mode, decay, input data, addr, we, busy, done);
`endif
endinterface

// File: rtl/exp_table_gen_mul.sv
// Unsigned fixed-point multiply: round half up at the FRAC_W boundary,
// then saturate to the all-ones DATA_W value.
module fx_mul_rnd_sat #(
    parameter int DATA_W = 18,
    parameter int FRAC_W = 17
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] p
);
    localparam int PW = 2 * DATA_W + 1;
    localparam logic [PW-1:0] HALF = PW'(1) << (FRAC_W - 1);

    logic [PW-1:0] full;
    logic [PW-1:0] shifted;

    assign full    = PW'(a) * PW'(b) + HALF;
    assign shifted = full >> FRAC_W;
    assign p       = (|shifted[PW-1:DATA_W]) ? '1 : shifted[DATA_W-1:0];
endmodule

// File: rtl/exp_table_gen.sv
// Writes DEPTH entries of q^k or q^(k*k) into a table RAM, one per two cycles,
// using a single shared multiplier. EXP_TABLE_SUM_EN adds a running sum output.
module exp_table_gen
    import exp_table_pkg::*;
#(
    parameter int DATA_W = 18,
    parameter int FRAC_W = 17,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input logic            clk,
    input logic            rst,
    exp_table_gen_if.master bus
);
    localparam logic [DATA_W-1:0] ONE    = DATA_W'(one_of(FRAC_W));
    localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(DEPTH - 1);

    state_t            state_reg, state_next;
    logic              fin_reg, fin_next;
    logic              start_ok;
    logic              mode_reg;
    logic [DATA_W-1:0] g_reg, r_reg, p_reg, g_next_reg;
    logic [ADDR_W-1:0] k_reg;
    logic [DATA_W-1:0] data_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              we_reg, busy_reg, done_reg;
    logic [DATA_W-1:0] decay_clamped;
    logic [DATA_W-1:0] mul_a, mul_b, mul_p;

    fx_mul_rnd_sat #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    assign decay_clamped = (bus.decay > ONE) ? ONE : bus.decay;

    // Operand steering for the shared multiplier; r still equals q during PREP.
    always_comb begin
        state_next = state_reg;
        fin_next   = 1'b0;
        start_ok   = 1'b0;
        mul_a      = g_reg;
        mul_b      = r_reg;
        case (state_reg)
            IDLE: begin
                // fin_reg marks the tail cycle before done, still counted as busy
                start_ok = bus.start && !fin_reg;
                if (start_ok) state_next = PREP;
            end
            PREP: begin
                mul_a      = r_reg;
                mul_b      = r_reg;
                state_next = EMIT;
            end
            EMIT: begin
                if (k_reg == LAST_K) begin
                    fin_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = STEP;
                end
            end
            STEP: begin
                mul_a      = r_reg;
                mul_b      = p_reg;
                state_next = EMIT;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            fin_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            fin_reg   <= fin_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_reg   <= MODE_EXP;
            g_reg      <= '0;
            r_reg      <= '0;
            p_reg      <= '0;
            g_next_reg <= '0;
            k_reg      <= '0;
            data_reg   <= '0;
            addr_reg   <= '0;
            we_reg     <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            we_reg   <= (state_reg == EMIT);
            busy_reg <= (state_next != IDLE) || fin_next;
            done_reg <= fin_reg;
            case (state_reg)
                IDLE: if (start_ok) begin
                    mode_reg <= bus.mode;
                    g_reg    <= ONE;
                    r_reg    <= decay_clamped;
                    k_reg    <= '0;
                end
                PREP: case (mode_reg)
                    MODE_GAUSS: p_reg <= mul_p;
                    MODE_EXP:   p_reg <= ONE;
                    default:    p_reg <= ONE;
                endcase
                EMIT: begin
                    data_reg   <= g_reg;
                    addr_reg   <= k_reg;
                    g_next_reg <= mul_p;
                end
                STEP: begin
                    g_reg <= g_next_reg;
                    r_reg <= mul_p;
                    k_reg <= k_reg + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef EXP_TABLE_SUM_EN
    logic [DATA_W+ADDR_W-1:0] sum_reg;

    always_ff @(posedge clk) begin
        if (rst)                    sum_reg <= '0;
        else if (start_ok)          sum_reg <= '0;
        else if (state_reg == EMIT) sum_reg <= sum_reg + (DATA_W + ADDR_W)'(g_reg);
    end

    assign bus.sum = sum_reg;
`endif

    assign bus.data = data_reg;
    assign bus.addr = addr_reg;
    assign bus.we   = we_reg;
    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
endmodule

// File: tb/tb_exp_table_gen.sv
// Directed bench: a DEPTH=4 instance for value checks and a DEPTH=1024
// instance for ordering, timing and mid-table reset checks.
module tb_exp_table_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    int wd[0:15];
    int wa[0:15];
    int wc[0:15];
    int nw, done_at, busy_n, addr_err, mono_err;

    always #5 clk = ~clk;

    exp_table_gen_if #(.DATA_W(18), .ADDR_W(10)) b4 ();
    exp_table_gen_if #(.DATA_W(18), .ADDR_W(10)) bk ();

    exp_table_gen #(.DEPTH(4)) u_small (.clk(clk), .rst(rst), .bus(b4));
    exp_table_gen u_big (.clk(clk), .rst(rst), .bus(bk));

    task automatic check(input string tag, input longint obs, input longint expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Starts a DEPTH=4 table; rs>0 re-pulses start (other mode, q=0) in that busy cycle.
    // Returns parked on the negedge of the done cycle.
    task automatic run4(input logic m, input int q, input int rs);
        b4.start = 1'b1; b4.mode = m; b4.decay = 18'(q);
        @(negedge clk);
        b4.start = 1'b0; b4.decay = 18'($urandom);
        nw = 0; done_at = -1; busy_n = 0;
        for (int c = 1; c <= 40 && done_at < 0; c++) begin
            if (b4.we && nw < 16) begin
                wd[nw] = int'(b4.data); wa[nw] = int'(b4.addr); wc[nw] = c; nw++;
            end
            if (b4.busy) busy_n++;
            if (b4.done) done_at = c;
            else begin
                b4.start = (c == rs); b4.mode = ~m; b4.decay = 18'd0;
                @(negedge clk);
                b4.start = 1'b0;
            end
        end
    endtask

    task automatic run_big(input logic m, input int q);
        int prev;
        bk.start = 1'b1; bk.mode = m; bk.decay = 18'(q);
        @(negedge clk);
        bk.start = 1'b0;
        nw = 0; done_at = -1; busy_n = 0; addr_err = 0; mono_err = 0; prev = 1 << 30;
        for (int c = 1; c <= 2200 && done_at < 0; c++) begin
            if (bk.we) begin
                if (int'(bk.addr) != nw) addr_err++;
                if (int'(bk.data) > prev) mono_err++;
                prev = int'(bk.data);
                if (nw < 16) wd[nw] = int'(bk.data);
                nw++;
            end
            if (bk.busy) busy_n++;
            if (bk.done) done_at = c;
            else @(negedge clk);
        end
    endtask

    task automatic check4(input string tag, input int e0, input int e1, input int e2, input int e3);
        int ev[4];
        ev = '{e0, e1, e2, e3};
        check({tag, "_count"}, nw, 4);
        check({tag, "_done_at"}, done_at, 10);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_data%0d", tag, k), wd[k], ev[k]);
            check($sformatf("%s_addr%0d", tag, k), wa[k], k);
            check($sformatf("%s_cyc%0d", tag, k), wc[k], 2 * k + 3);
        end
    endtask

    initial begin
        b4.start = 1'b0; b4.mode = 1'b0; b4.decay = '0;
        bk.start = 1'b0; bk.mode = 1'b0; bk.decay = '0;
        repeat (3) @(negedge clk);
        check("rst_data", b4.data, 0);
        check("rst_addr", b4.addr, 0);
        check("rst_we", b4.we, 0);
        check("rst_busy", b4.busy, 0);
        check("rst_done", b4.done, 0);
`ifdef EXP_TABLE_SUM_EN
        check("rst_sum", b4.sum, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        run4(1'b0, 65536, 0);
        $display("exp q=0.5: %0d %0d %0d %0d done_at=%0d", wd[0], wd[1], wd[2], wd[3], done_at);
        check4("exp_half", 131072, 65536, 32768, 16384);
        check("exp_half_busy", busy_n, 9);
`ifdef EXP_TABLE_SUM_EN
        check("exp_half_sum", b4.sum, 245760);
`endif
        @(negedge clk);

        run4(1'b1, 65536, 4);
        $display("gauss q=0.5 (restart ignored): %0d %0d %0d %0d", wd[0], wd[1], wd[2], wd[3]);
        check4("gauss_half", 131072, 65536, 8192, 256);
        check("gauss_half_busy_low", b4.busy, 0);
`ifdef EXP_TABLE_SUM_EN
        check("gauss_half_sum", b4.sum, 205056);
`endif

        run4(1'b1, 0, 0);
        $display("gauss q=0 back-to-back: %0d %0d %0d %0d", wd[0], wd[1], wd[2], wd[3]);
        check4("gauss_zero", 131072, 0, 0, 0);
        run4(1'b0, 0, 0);
        $display("exp q=0: %0d %0d %0d %0d", wd[0], wd[1], wd[2], wd[3]);
        check4("exp_zero", 131072, 0, 0, 0);
        run4(1'b0, 200000, 0);
        $display("exp q=clamp: %0d %0d %0d %0d", wd[0], wd[1], wd[2], wd[3]);
        check4("exp_clamp", 131072, 131072, 131072, 131072);
        run4(1'b1, 200000, 0);
        $display("gauss q=clamp: %0d %0d %0d %0d", wd[0], wd[1], wd[2], wd[3]);
        check4("gauss_clamp", 131072, 131072, 131072, 131072);
        @(negedge clk);

        run_big(1'b1, 131000);
        $display("big gauss: writes=%0d done_at=%0d busy=%0d", nw, done_at, busy_n);
        check("big_count", nw, 1024);
        check("big_addr_order", addr_err, 0);
        check("big_monotone", mono_err, 0);
        check("big_first", wd[0], 131072);
        check("big_done_at", done_at, 2050);
        check("big_busy", busy_n, 2049);
        @(negedge clk);

        bk.start = 1'b1; bk.mode = 1'b1; bk.decay = 18'd131000;
        @(negedge clk);
        bk.start = 1'b0;
        done_at = -1;
        for (int c = 0; c < 40 && done_at < 0; c++) begin
            if (bk.we && bk.addr == 10'd5) done_at = c;
            else @(negedge clk);
        end
        check("abort_reached_entry5", done_at >= 0, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_data", bk.data, 0);
        check("abort_addr", bk.addr, 0);
        check("abort_we", bk.we, 0);
        check("abort_busy", bk.busy, 0);
        check("abort_done", bk.done, 0);
        nw = 0; busy_n = 0;
        for (int c = 0; c < 40; c++) begin
            if (bk.we) nw++;
            if (bk.done) busy_n++;
            @(negedge clk);
        end
        $display("after abort: stray writes=%0d stray done=%0d", nw, busy_n);
        check("abort_no_we", nw, 0);
        check("abort_no_done", busy_n, 0);

        run_big(1'b0, 65536);
        $display("big exp after abort: writes=%0d done_at=%0d first=%0d %0d %0d %0d",
                 nw, done_at, wd[0], wd[1], wd[2], wd[3]);
        check("restart_count", nw, 1024);
        check("restart_addr_order", addr_err, 0);
        check("restart_done_at", done_at, 2050);
        check("restart_d0", wd[0], 131072);
        check("restart_d1", wd[1], 65536);
        check("restart_d2", wd[2], 32768);
        check("restart_d3", wd[3], 16384);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
